// File: rtl/epcs_pkg.sv
// Shared definitions for the EPCS command sequencer: op and error encodings,
// FSM state enum, busy blanking length and command legality helper.
package epcs_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } epcs_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_FLASH   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } epcs_err_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_RUN    = 3'd1,
        ST_RD_DRAIN  = 3'd2,
        ST_WR_LOAD   = 3'd3,
        ST_WR_PULSE  = 3'd4,
        ST_ER_PULSE  = 3'd5,
        ST_BUSY_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } epcs_state_e;

    localparam logic [1:0] BUSY_BLANK_CYC = 2'd2;
    localparam logic [8:0] MAX_LEN        = 9'd256;

    // Reserved op, or a read/write whose length falls outside 1..256.
    function automatic logic cmd_illegal(input logic [1:0] op, input logic [8:0] len);
        logic bad_len;
        bad_len = (len == 9'd0) || (len > MAX_LEN);
        return (op == OP_RSVD) || (((op == OP_READ) || (op == OP_WRITE)) && bad_len);
    endfunction

endpackage

// File: rtl/epcs_busy_wdog.sv
// Busy-wait watchdog: counts enabled cycles and flags expiry once the
// count reaches TIMEOUT_CYC. Only built with EPCS_CMD_SEQ_TIMEOUT_EN.
module epcs_busy_wdog #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd16_000_000
) (
    input  logic clkin,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [23:0] cnt_r;

    // Cycle counter, saturating at the limit.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            cnt_r <= 24'd0;
        end else if (clear) begin
            cnt_r <= 24'd0;
        end else if (enable && (cnt_r != TIMEOUT_CYC)) begin
            cnt_r <= cnt_r + 24'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Flag one cycle early so the FSM leaves after exactly TIMEOUT_CYC waiting cycles.
    assign expired = enable && (cnt_r >= (TIMEOUT_CYC - 24'd1));

endmodule

// File: rtl/epcs_cmd_seq.sv
// Host-command sequencer for an ASMI/EPCS flash controller (read, page write,
// sector erase). Optional busy watchdog enabled by EPCS_CMD_SEQ_TIMEOUT_EN.
module epcs_cmd_seq
    import epcs_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd16_000_000,
    parameter logic        ADDR_4B     = 1'b1
) (
    input  logic        clkin,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [1:0]  err,
    output logic        asmi_read,
    output logic        asmi_rden,
    output logic        asmi_write,
    output logic        asmi_wren,
    output logic        asmi_sector_erase,
    output logic        asmi_en4b_addr,
    output logic [31:0] asmi_addr,
    output logic [7:0]  asmi_datain,
    input  logic [7:0]  asmi_dataout,
    input  logic        asmi_busy,
    input  logic        asmi_data_valid,
    input  logic        asmi_illegal_write,
    input  logic        asmi_illegal_erase
);

    epcs_state_e state_r, state_nxt_s;
    epcs_op_e    op_r, op_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [8:0]  cnt_r, cnt_nxt_s;
    logic [1:0]  blank_r, blank_nxt_s;
    logic [1:0]  err_r, err_nxt_s;
    logic [7:0]  rd_data_r, rd_data_nxt_s;
    logic [31:0] asmi_addr_r, asmi_addr_nxt_s;
    logic [7:0]  datain_r, datain_nxt_s;
    logic        cmd_ready_r, rd_valid_r, wr_ready_r, done_r;
    logic        read_r, rden_r, write_r, wren_r, erase_r;
    logic        rd_valid_nxt_s, wr_ready_nxt_s;
    logic        read_nxt_s, rden_nxt_s, write_nxt_s, wren_nxt_s, erase_nxt_s;
    logic        wdog_expired_s;

`ifdef EPCS_CMD_SEQ_TIMEOUT_EN
    logic wdog_en_s;

    assign wdog_en_s = (state_r == ST_BUSY_WAIT) || (state_r == ST_RD_DRAIN);

    epcs_busy_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clkin   (clkin),
        .reset_n (reset_n),
        .enable  (wdog_en_s),
        .clear   (!wdog_en_s),
        .expired (wdog_expired_s)
    );
`else
    // Without the watchdog the limit has no consumer; fold it into a dead sink.
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYC;
    assign wdog_expired_s   = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt_s     = state_r;
        op_nxt_s        = op_r;
        addr_nxt_s      = addr_r;
        cnt_nxt_s       = cnt_r;
        blank_nxt_s     = blank_r;
        err_nxt_s       = err_r;
        rd_data_nxt_s   = rd_data_r;
        asmi_addr_nxt_s = asmi_addr_r;
        datain_nxt_s    = datain_r;
        rd_valid_nxt_s  = 1'b0;
        wr_ready_nxt_s  = 1'b0;
        read_nxt_s      = 1'b0;
        rden_nxt_s      = 1'b0;
        write_nxt_s     = 1'b0;
        wren_nxt_s      = 1'b0;
        erase_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_nxt_s   = epcs_op_e'(cmd_op);
                    addr_nxt_s = cmd_addr;
                    cnt_nxt_s  = cmd_len;
                    err_nxt_s  = ERR_OK;
                    if (cmd_illegal(cmd_op, cmd_len)) begin
                        err_nxt_s   = ERR_ILLEGAL;
                        state_nxt_s = ST_DONE;
                    end else if (cmd_op == OP_READ) begin
                        read_nxt_s      = 1'b1;
                        rden_nxt_s      = 1'b1;
                        asmi_addr_nxt_s = cmd_addr;
                        state_nxt_s     = ST_RD_RUN;
                    end else if (cmd_op == OP_WRITE) begin
                        state_nxt_s = ST_WR_LOAD;
                    end else begin
                        wren_nxt_s      = 1'b1;
                        erase_nxt_s     = 1'b1;
                        asmi_addr_nxt_s = cmd_addr;
                        state_nxt_s     = ST_ER_PULSE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_RUN: begin
                if (asmi_data_valid) begin
                    rd_data_nxt_s  = asmi_dataout;
                    rd_valid_nxt_s = 1'b1;
                    cnt_nxt_s      = cnt_r - 9'd1;
                    if (cnt_r == 9'd1) begin
                        state_nxt_s = ST_RD_DRAIN;
                    end else begin
                        rden_nxt_s = 1'b1;
                    end
                end else begin
                    rden_nxt_s = 1'b1;
                end
            end
            ST_RD_DRAIN: begin
                if (wdog_expired_s) begin
                    err_nxt_s   = ERR_TIMEOUT;
                    state_nxt_s = ST_DONE;
                end else if (!asmi_busy) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RD_DRAIN;
                end
            end
            ST_WR_LOAD: begin
                if (wr_valid) begin
                    wr_ready_nxt_s  = 1'b1;
                    datain_nxt_s    = wr_data;
                    asmi_addr_nxt_s = addr_r;
                    write_nxt_s     = 1'b1;
                    wren_nxt_s      = 1'b1;
                    state_nxt_s     = ST_WR_PULSE;
                end else begin
                    state_nxt_s = ST_WR_LOAD;
                end
            end
            ST_WR_PULSE, ST_ER_PULSE: begin
                blank_nxt_s = BUSY_BLANK_CYC;
                state_nxt_s = ST_BUSY_WAIT;
            end
            ST_BUSY_WAIT: begin
                if (asmi_illegal_write || asmi_illegal_erase) begin
                    err_nxt_s   = ERR_FLASH;
                    state_nxt_s = ST_DONE;
                end else if (wdog_expired_s) begin
                    err_nxt_s   = ERR_TIMEOUT;
                    state_nxt_s = ST_DONE;
                end else if (blank_r != 2'd0) begin
                    // The controller raises busy late; trust it only after blanking.
                    blank_nxt_s = blank_r - 2'd1;
                end else if (!asmi_busy) begin
                    if ((op_r == OP_WRITE) && (cnt_r != 9'd1)) begin
                        addr_nxt_s  = addr_r + 32'd1;
                        cnt_nxt_s   = cnt_r - 9'd1;
                        state_nxt_s = ST_WR_LOAD;
                    end else begin
                        cnt_nxt_s   = 9'd0;
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_BUSY_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_READ;
            addr_r      <= 32'd0;
            cnt_r       <= 9'd0;
            blank_r     <= 2'd0;
            err_r       <= ERR_OK;
            rd_data_r   <= 8'd0;
            asmi_addr_r <= 32'd0;
            datain_r    <= 8'd0;
            cmd_ready_r <= 1'b1;
            rd_valid_r  <= 1'b0;
            wr_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            read_r      <= 1'b0;
            rden_r      <= 1'b0;
            write_r     <= 1'b0;
            wren_r      <= 1'b0;
            erase_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            addr_r      <= addr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            blank_r     <= blank_nxt_s;
            err_r       <= err_nxt_s;
            rd_data_r   <= rd_data_nxt_s;
            asmi_addr_r <= asmi_addr_nxt_s;
            datain_r    <= datain_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            rd_valid_r  <= rd_valid_nxt_s;
            wr_ready_r  <= wr_ready_nxt_s;
            done_r      <= (state_nxt_s == ST_DONE);
            read_r      <= read_nxt_s;
            rden_r      <= rden_nxt_s;
            write_r     <= write_nxt_s;
            wren_r      <= wren_nxt_s;
            erase_r     <= erase_nxt_s;
        end
    end

    assign cmd_ready         = cmd_ready_r;
    assign wr_ready          = wr_ready_r;
    assign rd_data           = rd_data_r;
    assign rd_valid          = rd_valid_r;
    assign done              = done_r;
    assign err               = err_r;
    assign asmi_read         = read_r;
    assign asmi_rden         = rden_r;
    assign asmi_write        = write_r;
    assign asmi_wren         = wren_r;
    assign asmi_sector_erase = erase_r;
    assign asmi_en4b_addr    = ADDR_4B;
    assign asmi_addr         = asmi_addr_r;
    assign asmi_datain       = datain_r;

endmodule

// File: tb/tb_epcs_cmd_seq.sv
// Scoreboard bench for epcs_cmd_seq: directed commands push expectations,
// a negedge monitor pops and compares against what the DUT presents.
module tb_epcs_cmd_seq;

    logic        clkin = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = 32'd0;
    logic [8:0]  cmd_len = 9'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic [1:0]  err;
    logic        asmi_read, asmi_rden, asmi_write, asmi_wren, asmi_sector_erase, asmi_en4b_addr;
    logic [31:0] asmi_addr;
    logic [7:0]  asmi_datain;
    logic [7:0]  asmi_dataout = 8'd0;
    logic        asmi_busy = 1'b0;
    logic        asmi_data_valid = 1'b0;
    logic        asmi_illegal_write = 1'b0;
    logic        asmi_illegal_erase = 1'b0;

    always #5 clkin = ~clkin;

    epcs_cmd_seq #(.TIMEOUT_CYC(24'd100), .ADDR_4B(1'b1)) dut (
        .clkin(clkin), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .asmi_read(asmi_read), .asmi_rden(asmi_rden), .asmi_write(asmi_write),
        .asmi_wren(asmi_wren), .asmi_sector_erase(asmi_sector_erase),
        .asmi_en4b_addr(asmi_en4b_addr), .asmi_addr(asmi_addr),
        .asmi_datain(asmi_datain), .asmi_dataout(asmi_dataout),
        .asmi_busy(asmi_busy), .asmi_data_valid(asmi_data_valid),
        .asmi_illegal_write(asmi_illegal_write), .asmi_illegal_erase(asmi_illegal_erase)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  rd_q[$];
    logic [39:0] wr_q[$];
    logic [31:0] er_q[$];
    logic [1:0]  done_q[$];
    logic [7:0]  feed_q[$];

    // flash model state
    int rd_idx = 0;
    int busy_cnt = 0;
    int ill_cnt = 0;
    int pulse_busy = 5;
    bit rd_stall = 1'b0;
    bit stuck_busy = 1'b0;
    bit inject_ill = 1'b0;

    // monitor statistics
    int read_pulses = 0;
    int write_pulses = 0;
    int erase_pulses = 0;
    int strobe_cnt = 0;
    int both_hi = 0;
    int er_cyc = 0;
    int done_cyc = 0;

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if ((act < lo) || (act > hi)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Flash-controller model: data every cycle while rden, busy after pulses.
    always @(negedge clkin) begin
        if (!reset_n) begin
            rd_idx = 0;
            busy_cnt = 0;
            ill_cnt = 0;
            asmi_data_valid = 1'b0;
        end else begin
            asmi_data_valid = 1'b0;
            if (asmi_rden && !rd_stall) begin
                asmi_data_valid = 1'b1;
                asmi_dataout = 8'hA0 + rd_idx[7:0];
                rd_idx++;
            end
            if (asmi_rden) begin
                busy_cnt = 2;
            end else if (asmi_write || asmi_sector_erase) begin
                busy_cnt = pulse_busy;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            if ((asmi_write || asmi_sector_erase) && inject_ill) begin
                ill_cnt = 3;
                inject_ill = 1'b0;
            end else if (ill_cnt > 0) begin
                ill_cnt--;
            end
        end
        asmi_busy = stuck_busy || (busy_cnt > 0);
        asmi_illegal_write = (ill_cnt > 0);
    end

    // Host write-byte feeder: presents the queue head until the DUT consumes it.
    always @(negedge clkin) begin
        if (wr_ready && (feed_q.size() > 0)) void'(feed_q.pop_front());
        wr_valid = (feed_q.size() > 0);
        wr_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end

    // Monitor: pop expectations whenever the DUT presents an output event.
    always @(negedge clkin) begin
        if (reset_n) begin
            if (asmi_read || asmi_rden || asmi_write || asmi_wren || asmi_sector_erase) strobe_cnt++;
            if (rd_valid && wr_ready) both_hi++;
            if (asmi_read) read_pulses++;
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_extra", {56'd0, rd_data}, 64'hFFFF);
                else chk("rd_data", {56'd0, rd_data}, {56'd0, rd_q.pop_front()});
            end
            if (asmi_write) begin
                write_pulses++;
                chk("wr_wren", {63'd0, asmi_wren}, 64'd1);
                if (wr_q.size() == 0) chk("wr_extra", {24'd0, asmi_addr, asmi_datain}, 64'hFFFF_FFFF_FFFF);
                else chk("wr_addr_data", {24'd0, asmi_addr, asmi_datain}, {24'd0, wr_q.pop_front()});
            end
            if (asmi_sector_erase) begin
                erase_pulses++;
                er_cyc = cyc;
                chk("er_wren", {63'd0, asmi_wren}, 64'd1);
                if (er_q.size() == 0) chk("er_extra", {32'd0, asmi_addr}, 64'hFFFF_FFFF_FFFF);
                else chk("er_addr", {32'd0, asmi_addr}, {32'd0, er_q.pop_front()});
            end
            if (done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) chk("done_extra", {62'd0, err}, 64'hFF);
                else chk("done_err", {62'd0, err}, {62'd0, done_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [8:0] len);
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) break;
            @(negedge clkin);
        end
        if (!cmd_ready) chk("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_len = len;
        @(negedge clkin);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && (n < budget)) begin
            @(negedge clkin);
            n++;
        end
        if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
        @(negedge clkin);
    endtask

    initial begin
        int n;
        int s0;
        int w0;
        repeat (3) @(negedge clkin);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {62'd0, err}, 64'd0);
        chk("rst_strobes", {59'd0, asmi_read, asmi_rden, asmi_write, asmi_wren, asmi_sector_erase}, 64'd0);
        chk("rst_addr", {32'd0, asmi_addr}, 64'd0);
        chk("rst_rd_data", {56'd0, rd_data}, 64'd0);
        chk("rst_en4b", {63'd0, asmi_en4b_addr}, 64'd1);
        reset_n = 1'b1;
        @(negedge clkin);

        // read 4 bytes from 0x100
        for (int i = 0; i < 4; i++) rd_q.push_back(8'hA0 + 8'(i));
        done_q.push_back(2'b00);
        issue(2'b00, 32'h0000_0100, 9'd4);
        wait_done(200, n);
        chk("rd_dv_count", 64'(rd_idx), 64'd4);
        chk("rd_read_pulses", 64'(read_pulses), 64'd1);

        // write 2 bytes across the address wrap
        pulse_busy = 5;
        feed_q.push_back(8'h55);
        feed_q.push_back(8'hAA);
        wr_q.push_back({32'hFFFF_FFFF, 8'h55});
        wr_q.push_back({32'h0000_0000, 8'hAA});
        done_q.push_back(2'b00);
        issue(2'b01, 32'hFFFF_FFFF, 9'd2);
        wait_done(200, n);
        chk("wr_pulses", 64'(write_pulses), 64'd2);
        chk("wr_feed_empty", 64'(feed_q.size()), 64'd0);

        // sector erase, busy 50 cycles
        pulse_busy = 50;
        er_q.push_back(32'h0001_0000);
        done_q.push_back(2'b00);
        issue(2'b10, 32'h0001_0000, 9'd0);
        wait_done(300, n);
        chk_range("er_done_latency", done_cyc - er_cyc, 51, 53);
        chk("er_pulses", 64'(erase_pulses), 64'd1);

        // reserved op and zero-length write
        s0 = strobe_cnt;
        done_q.push_back(2'b01);
        issue(2'b11, 32'h0000_0000, 9'd4);
        wait_done(10, n);
        chk_range("op11_latency", n, 0, 1);
        done_q.push_back(2'b01);
        issue(2'b01, 32'h0000_0300, 9'd0);
        wait_done(10, n);
        chk_range("len0_latency", n, 0, 1);
        chk("illegal_no_strobe", 64'(strobe_cnt - s0), 64'd0);

        // flash reports illegal_write on the first byte of three
        pulse_busy = 5;
        w0 = write_pulses;
        inject_ill = 1'b1;
        feed_q.push_back(8'h11);
        feed_q.push_back(8'h22);
        feed_q.push_back(8'h33);
        wr_q.push_back({32'h0000_0200, 8'h11});
        done_q.push_back(2'b10);
        issue(2'b01, 32'h0000_0200, 9'd3);
        wait_done(200, n);
        feed_q.delete();
        repeat (4) @(negedge clkin);
        chk("ill_wr_pulses", 64'(write_pulses - w0), 64'd1);

`ifdef EPCS_CMD_SEQ_TIMEOUT_EN
        // busy stuck high: watchdog ends the erase with err=11
        pulse_busy = 0;
        stuck_busy = 1'b1;
        er_q.push_back(32'h0002_0000);
        done_q.push_back(2'b11);
        issue(2'b10, 32'h0002_0000, 9'd0);
        wait_done(400, n);
        chk_range("timeout_latency", done_cyc - er_cyc, 100, 102);
        stuck_busy = 1'b0;
`else
        // busy stuck high: sequencer keeps waiting, no timeout error
        pulse_busy = 0;
        stuck_busy = 1'b1;
        er_q.push_back(32'h0002_0000);
        done_q.push_back(2'b00);
        issue(2'b10, 32'h0002_0000, 9'd0);
        repeat (150) @(negedge clkin);
        chk("no_timeout_waiting", {63'd0, cmd_ready}, 64'd0);
        stuck_busy = 1'b0;
        wait_done(50, n);
        chk_range("no_timeout_latency", done_cyc - er_cyc, 150, 160);
`endif

        // reset in the middle of a stalled read
        rd_stall = 1'b1;
        issue(2'b00, 32'h0000_0040, 9'd4);
        repeat (3) @(negedge clkin);
        chk("midrd_rden_before", {63'd0, asmi_rden}, 64'd1);
        reset_n = 1'b0;
        @(posedge clkin);
        #1;
        chk("midrd_rden_after", {63'd0, asmi_rden}, 64'd0);
        chk("midrd_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("midrd_addr", {32'd0, asmi_addr}, 64'd0);
        @(negedge clkin);
        reset_n = 1'b1;
        rd_stall = 1'b0;
        repeat (3) @(negedge clkin);

        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("er_q_empty", 64'(er_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        chk("rdvalid_wrready_overlap", 64'(both_hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/epcs_cmd_seq.md
EPCS_CMD_SEQ -- requirements
Module: epcs_cmd_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24'd16_000_000, busy-wait watchdog limit in clkin cycles.
REQ-002 SHALL have parameter ADDR_4B, default 1'b1, value driven on asmi_en4b_addr.
REQ-003 SHALL use one clock, clkin; reset is reset_n, synchronous, active-low.
REQ-004 Ports (name direction width meaning):
 clkin  in  1  system clock
 reset_n  in  1  synchronous active-low reset
 cmd_valid  in  1  host command request
 cmd_ready  out  1  sequencer idle, command accepted when valid&ready
 cmd_op  in  2  00 read, 01 write, 10 sector erase, 11 reserved
 cmd_addr  in  32  start byte address
 cmd_len  in  9  byte count 1..256 (read/write; ignored for erase)
 wr_data  in  8  write byte
 wr_valid  in  1  write byte available
 wr_ready  out  1  write byte consumed this cycle
 rd_data  out  8  read byte
 rd_valid  out  1  rd_data valid, one-cycle strobe per byte
 done  out  1  one-cycle completion pulse
 err  out  2  00 ok, 01 illegal op/len, 10 flash illegal_write/erase, 11 timeout; valid with done
 asmi_read, asmi_rden, asmi_write, asmi_wren, asmi_sector_erase, asmi_en4b_addr  out  1 each  flash-controller controls
 asmi_addr  out  32  flash address
 asmi_datain  out  8  flash write byte
 asmi_dataout  in  8  flash read byte
 asmi_busy, asmi_data_valid, asmi_illegal_write, asmi_illegal_erase  in  1 each  flash-controller status

Function
REQ-005 SHALL be one FSM: IDLE, RD_RUN, RD_DRAIN, WR_LOAD, WR_PULSE, ER_PULSE, BUSY_WAIT, DONE.
REQ-006 IDLE: cmd_ready=1; on accept, latch op/addr/len; op=11 or len=0 (read/write) -> DONE with err=01, no flash activity.
REQ-007 Read: RD_RUN drives asmi_read=1 (first cycle only) and asmi_rden=1 with asmi_addr=latched addr; each asmi_data_valid -> rd_data=asmi_dataout, rd_valid=1 next cycle, remaining count decremented.
REQ-008 Read: rden SHALL drop the cycle the (len)th data_valid is seen; RD_DRAIN then waits asmi_busy=0 -> DONE.
REQ-009 Write: WR_LOAD waits wr_valid; on it, wr_ready=1 one cycle, asmi_datain=wr_data, asmi_addr=current addr; WR_PULSE asserts asmi_wren=1 and asmi_write=1 for exactly one cycle.
REQ-010 Write: after each byte go BUSY_WAIT; on busy low, addr+1 (32-bit wrap 0xFFFFFFFF->0), count-1; count 0 -> DONE else WR_LOAD.
REQ-011 Erase: ER_PULSE asserts asmi_wren=1, asmi_sector_erase=1 one cycle at latched addr, then BUSY_WAIT -> DONE.
REQ-012 BUSY_WAIT SHALL ignore asmi_busy for 2 cycles after the pulse, then exit on asmi_busy=0.
REQ-013 asmi_illegal_write/erase high in BUSY_WAIT -> abort remaining bytes, DONE with err=10.
REQ-014 DONE: done=1 one cycle, err held until next accept, return IDLE; cmd_valid during non-IDLE states SHALL be ignored.
REQ-015 rd_valid and wr_ready SHALL never be high in the same cycle.

Reset
REQ-016 reset_n=0 at any clkin edge, including mid-operation, SHALL force IDLE; all asmi_* strobes, rd_valid, wr_ready, done =0; err=00; rd_data, asmi_addr, asmi_datain =0; asmi_en4b_addr=ADDR_4B.
REQ-017 Reset mid-write leaves flash contents undefined; no retry performed.

Configuration
REQ-018 Macro EPCS_CMD_SEQ_TIMEOUT_EN defined: watchdog counts cycles in BUSY_WAIT/RD_DRAIN; reaching TIMEOUT_CYC -> DONE with err=11, all strobes low.
REQ-019 Undefined: no counter; waits indefinitely; err=11 never produced.

Structure
REQ-020 Shared package epcs_pkg SHALL hold op encodings, err codes, state enum, and the 2-cycle busy blanking constant.
REQ-021 Watchdog SHALL be sub-module epcs_busy_wdog (enable, clear, expired), instantiated only under EPCS_CMD_SEQ_TIMEOUT_EN.

Verification
REQ-022 Read op=00 addr=0x100 len=4, model returns A0..A3 -> four rd_valid with A0,A1,A2,A3; rden low after 4th; done, err=00.
REQ-023 Write addr=0xFFFFFFFF len=2, bytes 55,AA -> asmi_addr 0xFFFFFFFF then 0x00000000; two single-cycle write pulses; done, err=00.
REQ-024 Erase addr=0x10000, busy high 50 cycles -> one sector_erase pulse with wren; done 51..53 cycles later, err=00.
REQ-025 op=11 or write len=0 -> done within 2 cycles, err=01, no asmi strobe.
REQ-026 Write len=3 with illegal_write on byte 1 -> one write pulse only, err=10.
REQ-027 With EPCS_CMD_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, busy stuck high -> done err=11 at 100 cycles; reset_n low mid-read -> IDLE, rden low next edge.
